// File: rtl/expr_controller_if.sv
// rtl/expr_controller_if.sv - signal bundle between expr_controller, its host and the datapath
//
// Purpose: groups the start/busy/done handshake, the X operand, the datapath
// status flags and the datapath control lines into one interface.
// Modports:
//   master - the controller: receives start, input_X, zero, overflow;
//            drives LX, LS, LH, H, M0, M1, M2, busy, done, err.
//   slave  - host plus datapath: the opposite directions.
interface expr_controller_if #(
  parameter int X_W = 8
);
  logic           start;
  logic [X_W-1:0] input_X;
  logic           zero;
  logic           overflow;
  logic           LX;
  logic           LS;
  logic           LH;
  logic           H;
  logic [1:0]     M0;
  logic [1:0]     M1;
  logic [1:0]     M2;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    input  start, input_X, zero, overflow,
    output LX, LS, LH, H, M0, M1, M2, busy, done, err
  );

  modport slave (
    output start, input_X, zero, overflow,
    input  LX, LS, LH, H, M0, M1, M2, busy, done, err
  );
endinterface

// File: rtl/expr_controller.sv
// rtl/expr_controller.sv - FSM controller sequencing the datapath to compute S = A*X + B - C
//
// Purpose: drives register loads, ALU op and mux selects so the datapath
// evaluates S = A*X + B - C, the product being X repeated additions of A
// counted down by an internal counter loaded from input_X.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active high
//   bus  - expr_controller_if.master:
//            start, input_X     request / X operand (sampled in IDLE only)
//            zero, overflow     datapath flags
//            LX, LS, LH         register loads (Reg_X, Reg_S, Reg_H)
//            H                  ALU op (OP_ADD / OP_SUB)
//            M0, M1, M2         mux selects
//            busy, done, err    status towards the host
// Configuration:
//   OVF_ABORT_EN - when defined, an ALU overflow in any cycle that loads
//                  Reg_S aborts into ERR (done and err together); when
//                  undefined the overflow flag is ignored and err is 0.
module expr_controller #(
  parameter int   X_W    = 8,
  parameter logic OP_ADD = 1'b0,
  parameter logic OP_SUB = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  expr_controller_if.master bus
);

  // M0 source select
  localparam logic [1:0] M0_ZERO = 2'd0;
  localparam logic [1:0] M0_A    = 2'd1;
  localparam logic [1:0] M0_B    = 2'd2;
  localparam logic [1:0] M0_C    = 2'd3;
  // M1 source select
  localparam logic [1:0] M1_M0   = 2'd0;
  // M2 source select
  localparam logic [1:0] M2_M0   = 2'd1;
  localparam logic [1:0] M2_S    = 2'd2;

  localparam logic [X_W-1:0] CNT_ZERO = '0;
  localparam logic [X_W-1:0] CNT_ONE  = {{(X_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_MUL  = 3'd2,
    ST_ADDB = 3'd3,
    ST_SUBC = 3'd4,
`ifdef OVF_ABORT_EN
    ST_ERR  = 3'd6,
`endif
    ST_DONE = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] cnt_q, cnt_d;
`ifdef OVF_ABORT_EN
  logic           err_q, err_d;
`endif

  logic           lx;
  logic           ls;
  logic           h;
  logic [1:0]     m0;
  logic [1:0]     m1;
  logic [1:0]     m2;
  logic           busy;
  logic           done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
`ifdef OVF_ABORT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef OVF_ABORT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef OVF_ABORT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CLR;
          cnt_d   = bus.input_X;
`ifdef OVF_ABORT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_CLR: begin
        state_d = (cnt_q != CNT_ZERO) ? ST_MUL : ST_ADDB;
      end
      ST_MUL: begin
        // cnt holds the additions still to do, including this one
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q > CNT_ONE) ? ST_MUL : ST_ADDB;
      end
      ST_ADDB: state_d = ST_SUBC;
      ST_SUBC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
`ifdef OVF_ABORT_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef OVF_ABORT_EN
    // Overflow is only meaningful when the ALU result is being stored
    if (ls && bus.overflow) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
`endif
  end

  // Output logic
  always_comb begin
    lx   = 1'b0;
    ls   = 1'b0;
    h    = 1'b0;
    m0   = M0_ZERO;
    m1   = M1_M0;
    m2   = 2'd0;
    busy = 1'b1;
    done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        // Mealy load of Reg_X; held low while reset is asserted
        lx   = bus.start & ~rst;
      end
      ST_CLR: begin
        m0 = M0_ZERO;
        m1 = M1_M0;
        m2 = M2_M0;
        h  = OP_ADD;
        ls = 1'b1;
      end
      ST_MUL: begin
        m0 = M0_A;
        m1 = M1_M0;
        m2 = M2_S;
        h  = OP_ADD;
        ls = 1'b1;
      end
      ST_ADDB: begin
        m0 = M0_B;
        m1 = M1_M0;
        m2 = M2_S;
        h  = OP_ADD;
        ls = 1'b1;
      end
      ST_SUBC: begin
        m0 = M0_C;
        m1 = M1_M0;
        m2 = M2_S;
        h  = OP_SUB;
        ls = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
`ifdef OVF_ABORT_EN
      ST_ERR: begin
        done = 1'b1;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.LX   = lx;
  assign bus.LS   = ls;
  assign bus.LH   = 1'b0;
  assign bus.H    = h;
  assign bus.M0   = m0;
  assign bus.M1   = m1;
  assign bus.M2   = m2;
  assign bus.busy = busy;
  assign bus.done = done;
`ifdef OVF_ABORT_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_expr_controller.sv
// tb/tb_expr_controller.sv - scoreboard bench for expr_controller with a behavioural datapath
`timescale 1ns/1ps
module tb_expr_controller;
  localparam int X_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  expr_controller_if #(.X_W(X_W)) bus ();
  expr_controller #(.X_W(X_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural datapath driven by the controller
  logic [15:0] a_in = 16'h0, b_in = 16'h0, c_in = 16'h0;
  logic [15:0] reg_s = 16'h0, reg_x = 16'h0, reg_h = 16'h0;
  logic [15:0] m0_out, m1_out, m2_out, alu_out;

  always_comb begin
    case (bus.M0)
      2'd0:    m0_out = 16'h0;
      2'd1:    m0_out = a_in;
      2'd2:    m0_out = b_in;
      default: m0_out = c_in;
    endcase
    case (bus.M1)
      2'd0:    m1_out = m0_out;
      2'd1:    m1_out = reg_x;
      2'd2:    m1_out = reg_s;
      default: m1_out = reg_h;
    endcase
    case (bus.M2)
      2'd0:    m2_out = reg_x;
      2'd1:    m2_out = m0_out;
      2'd2:    m2_out = reg_s;
      default: m2_out = reg_h;
    endcase
    alu_out = bus.H ? (m2_out - m1_out) : (m2_out + m1_out);
  end

  assign bus.zero     = (reg_s == 16'h0);
  assign bus.overflow = bus.H ? ((m2_out[15] != m1_out[15]) && (alu_out[15] != m2_out[15]))
                              : ((m2_out[15] == m1_out[15]) && (alu_out[15] != m2_out[15]));

  always @(posedge clk) begin
    if (bus.LS) reg_s <= alu_out;
    if (bus.LX) reg_x <= {8'h00, bus.input_X};
    if (bus.LH) reg_h <= alu_out;
  end

  // Scoreboard and reference model
  typedef struct {
    logic [15:0] res;
    bit          err;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   busy_from = 0;
  int   idle_at   = 0;
  bit   m_err     = 1'b0;
  bit   next_idle = 1'b1;
  int   n_tests   = 0;
  int   n_fail    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outcome of one evaluation accepted in cycle c0
  function automatic exp_t predict(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input int x, input int c0);
    exp_t   e;
    longint v;
    v          = longint'(a) * longint'(x) + longint'(b) - longint'(c);
    e.res      = v[15:0];
    e.err      = 1'b0;
    e.done_cyc = c0 + x + 4;
`ifdef OVF_ABORT_EN
    begin
      int s;
      int t;
      s = 0;
      for (int i = 1; i <= x; i++) begin
        t = s + $signed(a);
        if (t > 32767 || t < -32768) begin
          e.err = 1'b1; e.done_cyc = c0 + i + 2; return e;
        end
        s = t;
      end
      t = s + $signed(b);
      if (t > 32767 || t < -32768) begin
        e.err = 1'b1; e.done_cyc = c0 + x + 3; return e;
      end
      s = t;
      t = s - $signed(c);
      if (t > 32767 || t < -32768) begin
        e.err = 1'b1; e.done_cyc = c0 + x + 4; return e;
      end
    end
`endif
    return e;
  endfunction

  // Monitor: one pass per cycle, mid-cycle
  always @(negedge clk) begin
    int   c;
    bit   busy_e;
    bit   acc;
    exp_t f;
    exp_t e;
    c = cyc;
    if (rst) begin
      chk("reset_outputs", {bus.LX, bus.LS, bus.LH, bus.H, bus.M0, bus.M1, bus.M2,
                            bus.busy, bus.done, bus.err}, 64'd0);
      sb.delete();
      busy_from = 0;
      idle_at   = 0;
      m_err     = 1'b0;
      next_idle = 1'b1;
    end else begin
      busy_e = (c >= busy_from) && (c < idle_at);
      acc    = bus.start && !busy_e;
      chk("lx", bus.LX, acc);
      chk("busy", bus.busy, busy_e);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", bus.done, 1'b0);
        end else begin
          f = sb.pop_front();
          chk("done_cycle", c, f.done_cyc);
          chk("err_at_done", bus.err, f.err);
          if (!f.err) chk("result", reg_s, f.res);
          m_err = f.err;
        end
      end else begin
        chk("err_level", bus.err, m_err);
        if (sb.size() > 0 && c > sb[0].done_cyc) begin
          chk("done_missing", bus.done, 1'b1);
          void'(sb.pop_front());
        end
      end
      if (acc) begin
        e = predict(a_in, b_in, c_in, int'(bus.input_X), c);
        sb.push_back(e);
        busy_from = c + 1;
        idle_at   = e.done_cyc + 1;
        m_err     = 1'b0;
      end
      next_idle = !((c + 1 >= busy_from) && (c + 1 < idle_at));
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!next_idle && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", next_idle, 1'b1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [7:0] x, input int hold);
    wait_idle();
    a_in = a; b_in = b; c_in = c;
    bus.input_X = x;
    bus.start   = 1'b1;
    repeat (hold) tick();
    bus.start   = 1'b0;
    bus.input_X = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start   = 1'b0;
    bus.input_X = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run(16'd3, 16'd10, 16'd2, 8'd4, 1);
    run(16'd5, 16'd7, 16'd7, 8'd0, 1);
    run(16'd9, 16'd4, 16'd1, 8'd2, 8);

    // Reset during the third MUL cycle of an X=10 run
    wait_idle();
    a_in = 16'd2; b_in = 16'd3; c_in = 16'd1;
    bus.input_X = 8'd10;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {bus.LX, bus.LS, bus.LH, bus.H, bus.M0, bus.M1, bus.M2,
                               bus.busy, bus.done, bus.err}, 64'd0);
    tick();
    run(16'd1, 16'd0, 16'd0, 8'd1, 1);

    run(16'h7000, 16'h0, 16'h0, 8'd3, 1);
    run(16'hFFFF, 16'h0, 16'hFFFE, 8'd2, 1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] x;
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      run(16'($urandom), 16'($urandom), 16'($urandom), x, $urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) tick();
    end

    wait_idle();
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
